// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: requests one word at a time from instruction memory,
// presents it to decode, then selects the next PC from Control's jump/branch outcome.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [5:0]  opcode,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        resolve_valid,
  input  logic        branch,
  input  logic        jump,
  input  logic        zero,
  output logic [31:0] fetch_count
);

  typedef enum logic [1:0] {
    S_REQ     = 2'd0,
    S_ISSUE   = 2'd1,
    S_RESOLVE = 2'd2
  } state_t;

  localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

  state_t      state_r;
  state_t      state_s;
  logic [31:0] pc_r;
  logic [31:0] instr_r;
  logic [31:0] instr_pc_r;
  logic [31:0] fetch_count_r;
  logic [31:0] resolve_pc_s;

  // Jump beats a taken branch; everything else falls through to pc4.
  function automatic logic [31:0] next_pc(
    input logic [31:0] from_pc,
    input logic [31:0] word,
    input logic        do_jump,
    input logic        do_branch,
    input logic        is_zero
  );
    logic [31:0] pc4;
    pc4 = from_pc + 32'd4;
    if (do_jump) begin
      next_pc = {pc4[31:28], word[25:0], 2'b00};
    end else if (do_branch && is_zero) begin
      next_pc = pc4 + {{14{word[15]}}, word[15:0], 2'b00};
    end else begin
      next_pc = pc4;
    end
  endfunction

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= S_REQ;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic and resolved PC.
  always_comb begin
    state_s      = state_r;
    resolve_pc_s = next_pc(instr_pc_r, instr_r, jump, branch, zero);
    case (state_r)
      S_REQ: begin
        if (imem_ack) begin
          state_s = S_ISSUE;
        end else begin
          state_s = S_REQ;
        end
      end
      S_ISSUE: begin
        if (instr_ready) begin
          state_s = S_RESOLVE;
        end else begin
          state_s = S_ISSUE;
        end
      end
      S_RESOLVE: begin
        if (resolve_valid) begin
          state_s = S_REQ;
        end else begin
          state_s = S_RESOLVE;
        end
      end
      default: begin
        state_s = S_REQ;
      end
    endcase
  end

  // Datapath: capture on ack, count accepts, update PC on resolve.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_r          <= RESET_PC_ALIGNED;
      instr_r       <= 32'h0000_0000;
      instr_pc_r    <= 32'h0000_0000;
      fetch_count_r <= 32'h0000_0000;
    end else begin
      case (state_r)
        S_REQ: begin
          if (imem_ack) begin
            instr_r    <= imem_rdata;
            instr_pc_r <= pc_r;
          end
        end
        S_ISSUE: begin
          if (instr_ready) begin
            fetch_count_r <= fetch_count_r + 32'd1;
          end
        end
        S_RESOLVE: begin
          if (resolve_valid) begin
            pc_r <= {resolve_pc_s[31:2], 2'b00};
          end
        end
        default: begin
          pc_r <= pc_r;
        end
      endcase
    end
  end

  assign imem_req    = (state_r == S_REQ) && !reset;
  assign imem_addr   = pc_r;
  assign instr       = instr_r;
  assign opcode      = instr_r[31:26];
  assign instr_pc    = instr_pc_r;
  assign instr_valid = (state_r == S_ISSUE) && !reset;
  assign fetch_count = fetch_count_r;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: a table of fetch/resolve records walked through
// the full handshake, plus hand-written reset sequences.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [5:0]  opcode;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        resolve_valid;
  logic        branch;
  logic        jump;
  logic        zero;
  logic [31:0] fetch_count;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  instr_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr(instr), .opcode(opcode), .instr_pc(instr_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .resolve_valid(resolve_valid), .branch(branch), .jump(jump), .zero(zero),
    .fetch_count(fetch_count)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] rdata;
    int          ack_dly;
    int          rdy_dly;
    int          res_dly;
    logic        j;
    logic        b;
    logic        z;
    logic [5:0]  op;
    logic [31:0] next;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    imem_ack = 1'b0; imem_rdata = 32'h0000_0000; instr_ready = 1'b0;
    resolve_valid = 1'b0; branch = 1'b0; jump = 1'b0; zero = 1'b0;
  endtask

  initial begin
    logic        hold_ok;
    logic [31:0] exp_cnt;

    //            pc            rdata        ack rdy res  j     b     z     op      next
    vecs[0]  = '{32'h0000_0000, 32'h012A_4020, 5, 0, 0, 1'b0, 1'b0, 1'b0, 6'h00, 32'h0000_0004};
    vecs[1]  = '{32'h0000_0004, 32'h0000_0000, 0, 1, 1, 1'b0, 1'b1, 1'b0, 6'h00, 32'h0000_0008};
    vecs[2]  = '{32'h0000_0008, 32'h1000_0003, 0, 0, 0, 1'b0, 1'b1, 1'b1, 6'h04, 32'h0000_0018};
    vecs[3]  = '{32'h0000_0018, 32'h0800_0002, 0, 0, 0, 1'b1, 1'b0, 1'b0, 6'h02, 32'h0000_0008};
    vecs[4]  = '{32'h0000_0008, 32'h1000_0003, 1, 0, 0, 1'b0, 1'b1, 1'b0, 6'h04, 32'h0000_000C};
    vecs[5]  = '{32'h0000_000C, 32'h0800_0004, 0, 0, 0, 1'b1, 1'b0, 1'b0, 6'h02, 32'h0000_0010};
    vecs[6]  = '{32'h0000_0010, 32'h1000_FFFF, 0, 0, 0, 1'b0, 1'b1, 1'b1, 6'h04, 32'h0000_0010};
    vecs[7]  = '{32'h0000_0010, 32'h1000_FFFF, 0, 0, 2, 1'b0, 1'b1, 1'b0, 6'h04, 32'h0000_0014};
    vecs[8]  = '{32'h0000_0014, 32'h0800_0008, 0, 0, 0, 1'b1, 1'b0, 1'b0, 6'h02, 32'h0000_0020};
    vecs[9]  = '{32'h0000_0020, 32'h0800_0040, 0, 0, 0, 1'b1, 1'b1, 1'b1, 6'h02, 32'h0000_0100};
    vecs[10] = '{32'h0000_0100, 32'h1000_FFBE, 0, 0, 0, 1'b0, 1'b1, 1'b1, 6'h04, 32'hFFFF_FFFC};
    vecs[11] = '{32'hFFFF_FFFC, 32'h0800_0010, 0, 0, 0, 1'b1, 1'b0, 1'b0, 6'h02, 32'h0000_0040};
    vecs[12] = '{32'h0000_0040, 32'h8C01_0000, 0, 0, 0, 1'b0, 1'b0, 1'b0, 6'h23, 32'h0000_0044};

    idle_inputs();
    reset = 1'b1;
    step();
    check("rst_req", {31'd0, imem_req}, 32'd0);
    check("rst_valid", {31'd0, instr_valid}, 32'd0);
    step();
    check("rst_count", fetch_count, 32'd0);
    check("rst_instr", instr, 32'd0);
    check("rst_instr_pc", instr_pc, 32'd0);
    reset = 1'b0;
    step();
    check("post_rst_req", {31'd0, imem_req}, 32'd1);
    check("post_rst_addr", imem_addr, 32'd0);

    exp_cnt = 32'd0;
    for (int v = 0; v < 13; v++) begin
      check($sformatf("v%0d_req", v), {31'd0, imem_req}, 32'd1);
      check($sformatf("v%0d_addr", v), imem_addr, vecs[v].pc);
      hold_ok = 1'b1;
      for (int i = 0; i < vecs[v].ack_dly; i++) begin
        instr_ready = 1'b1; resolve_valid = 1'b1; jump = 1'b1;
        step();
        if (!(imem_req === 1'b1 && imem_addr === vecs[v].pc && instr_valid === 1'b0)) hold_ok = 1'b0;
      end
      idle_inputs();
      if (vecs[v].ack_dly > 0) check($sformatf("v%0d_req_hold", v), {31'd0, hold_ok}, 32'd1);

      imem_ack = 1'b1; imem_rdata = vecs[v].rdata;
      step();
      idle_inputs();
      check($sformatf("v%0d_valid", v), {31'd0, instr_valid}, 32'd1);
      check($sformatf("v%0d_instr", v), instr, vecs[v].rdata);
      check($sformatf("v%0d_opcode", v), {26'd0, opcode}, {26'd0, vecs[v].op});
      check($sformatf("v%0d_instr_pc", v), instr_pc, vecs[v].pc);
      check($sformatf("v%0d_issue_req", v), {31'd0, imem_req}, 32'd0);

      for (int i = 0; i < vecs[v].rdy_dly; i++) begin
        imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF; resolve_valid = 1'b1; jump = 1'b1;
        step();
        idle_inputs();
        check($sformatf("v%0d_issue_hold", v), instr, vecs[v].rdata);
        check($sformatf("v%0d_issue_valid", v), {31'd0, instr_valid}, 32'd1);
      end

      instr_ready = 1'b1;
      step();
      idle_inputs();
      exp_cnt = exp_cnt + 32'd1;
      check($sformatf("v%0d_count", v), fetch_count, exp_cnt);
      check($sformatf("v%0d_res_valid", v), {31'd0, instr_valid}, 32'd0);

      for (int i = 0; i < vecs[v].res_dly; i++) begin
        instr_ready = 1'b1; imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        step();
        idle_inputs();
        check($sformatf("v%0d_res_wait_req", v), {31'd0, imem_req}, 32'd0);
        check($sformatf("v%0d_res_wait_cnt", v), fetch_count, exp_cnt);
        check($sformatf("v%0d_res_wait_instr", v), instr, vecs[v].rdata);
      end

      resolve_valid = 1'b1; jump = vecs[v].j; branch = vecs[v].b; zero = vecs[v].z;
      step();
      idle_inputs();
      check($sformatf("v%0d_next_addr", v), imem_addr, vecs[v].next);
    end

    // Reset while waiting in S_RESOLVE: the jump to 0x40 must be discarded.
    check("rr_req", {31'd0, imem_req}, 32'd1);
    check("rr_addr", imem_addr, 32'h0000_0044);
    imem_ack = 1'b1; imem_rdata = 32'h0800_0010;
    step();
    idle_inputs();
    instr_ready = 1'b1;
    step();
    idle_inputs();
    check("rr_count_pre", fetch_count, 32'd14);
    reset = 1'b1; resolve_valid = 1'b1; jump = 1'b1;
    #1;
    check("rr_req_in_reset", {31'd0, imem_req}, 32'd0);
    step();
    idle_inputs();
    check("rr_valid_in_reset", {31'd0, instr_valid}, 32'd0);
    check("rr_count_clr", fetch_count, 32'd0);
    check("rr_instr_clr", instr, 32'd0);
    check("rr_instr_pc_clr", instr_pc, 32'd0);
    reset = 1'b0;
    step();
    check("rr_restart_req", {31'd0, imem_req}, 32'd1);
    check("rr_restart_addr", imem_addr, 32'd0);

    // Reset while in S_ISSUE: valid drops and the instruction is discarded.
    imem_ack = 1'b1; imem_rdata = 32'h2001_0005;
    step();
    idle_inputs();
    check("ri_valid", {31'd0, instr_valid}, 32'd1);
    reset = 1'b1; instr_ready = 1'b1;
    #1;
    check("ri_valid_in_reset", {31'd0, instr_valid}, 32'd0);
    step();
    idle_inputs();
    reset = 1'b0;
    step();
    check("ri_count", fetch_count, 32'd0);
    check("ri_req", {31'd0, imem_req}, 32'd1);
    check("ri_instr", instr, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
